// File: rtl/apb_master_arbiter_if.sv
// Purpose: bundles requester command/response and APB-master command signals of apb_master_arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake on the command side; response is a one-cycle pulse.
//
// Modports:
//   master - the arbiter's view: consumes requester commands and bus status,
//            drives req_ready/rsp_* and the APB master command inputs.
//   slave  - the environment's view (requesters plus APB master/bus).
// Parameters must match the ones given to apb_master_arbiter.
interface apb_master_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int STRB_WIDTH    = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_write;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
    logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_rdata;
    logic                             rsp_slverr;
    logic                             busy;
    logic [ID_W-1:0]                  grant_id;

    // APB master command side
    logic                             Transfer;
    logic [ADDRESS_WIDTH-1:0]         IN_ADDR;
    logic [DATA_WIDTH-1:0]            IN_DATA;
    logic                             IN_WRITE;
    logic [STRB_WIDTH-1:0]            IN_STRB;
    logic                             PENABLE;
    logic                             PREADY;
    logic [DATA_WIDTH-1:0]            OUT_RDATA;
    logic                             OUT_SLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, grant_id,
        output Transfer, IN_ADDR, IN_DATA, IN_WRITE, IN_STRB,
        input  PENABLE, PREADY, OUT_RDATA, OUT_SLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, grant_id,
        input  Transfer, IN_ADDR, IN_DATA, IN_WRITE, IN_STRB,
        output PENABLE, PREADY, OUT_RDATA, OUT_SLVERR
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Purpose: shares one APB master between NUM_REQ requesters (round-robin or fixed priority).
// Latency: accept at edge N, Transfer high from N; zero-wait transfer completes (rsp_valid) at edge N+3.
// Backpressure: req_ready only in IDLE, one-hot to the winner; wait states stretch BUSY without limit.
//
// Ports:
//   PCLK, PRESET        clock, asynchronous active-high reset
//   bus (master modport):
//     req_valid/write/addr/wdata/strb  packed per-requester commands (requester i in slice i)
//     req_ready            one-hot accept, combinational, IDLE only
//     rsp_valid            one-hot one-cycle completion pulse to the owner
//     rsp_rdata/slverr     result of the last completion, held until the next one
//     busy, grant_id       transfer in flight / current or last owner
//     Transfer, IN_*       command inputs of the APB master
//     PENABLE, PREADY      bus status used to detect completion
//     OUT_RDATA/SLVERR     result from the APB master
//
// Build option: define FIXED_PRIO_EN for fixed priority (lowest index wins);
// the round-robin pointer is then not built.
module apb_master_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int STRB_WIDTH    = 4
) (
    input logic                  PCLK,
    input logic                  PRESET,
    apb_master_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state;
    logic [ID_W-1:0]          grant_id_q;
    logic [NUM_REQ-1:0]       rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q;
    logic                     rsp_slverr_q;

    // command captured at acceptance; requester inputs are don't-care afterwards
    logic                     lat_write;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [STRB_WIDTH-1:0]    lat_strb;

    logic                     win_found;
    logic [ID_W-1:0]          win_idx;
    int                       cand;
    logic [NUM_REQ-1:0]       req_ready_c;
    logic                     xfer_done;

`ifndef FIXED_PRIO_EN
    // owner of the most recent grant; search starts just after it
    logic [ID_W-1:0]          last;
`endif

    // PREADY only counts in the ACCESS phase, i.e. with PENABLE high
    assign xfer_done = (state == BUSY) && bus.PENABLE && bus.PREADY;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last) + 1 + k) % NUM_REQ;
`endif
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Accept is combinational so the handshake completes at the very edge
    // the FSM latches the command. Masked during reset so nothing looks
    // accepted while the FSM is being cleared.
    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && win_found && !PRESET) begin
            req_ready_c[win_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state        <= IDLE;
            grant_id_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_strb     <= '0;
`ifndef FIXED_PRIO_EN
            // first search after reset starts at requester 0
            last         <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_write  <= bus.req_write[win_idx];
                        lat_addr   <= bus.req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        lat_wdata  <= bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        lat_strb   <= bus.req_strb[win_idx*STRB_WIDTH +: STRB_WIDTH];
                        grant_id_q <= win_idx;
`ifndef FIXED_PRIO_EN
                        last       <= win_idx;
`endif
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_done) begin
                        rsp_valid_q[grant_id_q] <= 1'b1;
                        // write completions report zero read data
                        rsp_rdata_q  <= lat_write ? '0 : bus.OUT_RDATA;
                        rsp_slverr_q <= bus.OUT_SLVERR;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
    assign bus.busy       = (state == BUSY);
    assign bus.grant_id   = grant_id_q;

    // Dropping Transfer on the completing cycle makes the master fall back
    // to IDLE instead of chaining straight into another SETUP.
    assign bus.Transfer   = (state == BUSY) && !(bus.PENABLE && bus.PREADY);
    assign bus.IN_ADDR    = lat_addr;
    assign bus.IN_DATA    = lat_wdata;
    assign bus.IN_WRITE   = lat_write;
    assign bus.IN_STRB    = lat_strb;

endmodule
